ram_wt: RTL and testbench

RAM_WT -- requirements
Module: ram_wt

---
 rtl/cpu15_pkg.sv | 20 ++
 rtl/io_out_port.sv | 71 +++++++
 rtl/ram_wt.sv | 93 +++++++++
 tb/tb_ram_wt.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// Shared constants and types for the cpu15 memory slice (ram_wt, ram_dc).
//   DATA_W / AD_W : data word and address widths
//   RAM_BASE/SIZE : RAM window in the address map (word n at RAM_BASE + n)
//   IO_MATCH      : value of address bits [AD_W-1:AD_W-2] selecting the output port
//   io_state_t    : output-port FSM states
package cpu15_pkg;

  localparam int DATA_W   = 16;
  localparam int AD_W     = 8;
  localparam int RAM_BASE = 0;
  localparam int RAM_SIZE = 8;

  localparam logic [1:0] IO_MATCH = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } io_state_t;

endpackage

// File: rtl/io_out_port.sv
// Single-entry output port with a valid/ack handshake.
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset (clears data, drops valid)
//   wr    : port write request this cycle (already address-decoded)
//   ack   : consumer has taken dout this cycle
//   din   : write data
//   dout  : held output word
//   valid : dout holds unconsumed data (FSM in FULL)
//   busy  : write request stalled this cycle; requester must hold it
module io_out_port
#(
  parameter int DATA_W = cpu15_pkg::DATA_W
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              ack,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              busy
);

  import cpu15_pkg::*;

  io_state_t state_q;
  io_state_t state_d;
  logic      load;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        // ack is meaningless with nothing held, so it is ignored here
        if (wr) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ack) begin
          // consumer frees the slot in the same cycle a new word arrives:
          // refill without passing through IDLE
          if (wr) load    = 1'b1;
          else    state_d = IDLE;
        end else if (wr) begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // reset wins over everything, so nothing is ever reported stalled under it
    if (rst) busy = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      if (load) dout <= din;
    end
  end

  assign valid = (state_q == FULL);

endmodule

// File: rtl/ram_wt.sv
// Write side of the cpu15 RAM: address decode, 8-word register RAM, output
// port, and sticky unmapped-address flag. RAM_0..RAM_7 feed ram_dc directly.
//   CLK_WT     : clock, all state on rising edge
//   RESET      : synchronous active-high reset
//   RAM_WEN    : write request this cycle
//   RAM_AD_IN  : write address
//   RAM_IN     : write data
//   IO64_ACK   : consumer has taken IO64_OUT
//   RAM_0..7   : stored RAM words
//   IO64_OUT   : output-port data
//   IO64_VALID : IO64_OUT holds unconsumed data
//   RAM_BUSY   : current write stalled (port full, no ack)
//   AD_ERR     : sticky, set by a write to an unmapped address
module ram_wt
#(
  parameter int DATA_W    = cpu15_pkg::DATA_W,
  parameter int AD_W      = cpu15_pkg::AD_W,
  parameter int RAM_DEPTH = cpu15_pkg::RAM_SIZE
)
(
  input  logic              CLK_WT,
  input  logic              RESET,
  input  logic              RAM_WEN,
  input  logic [AD_W-1:0]   RAM_AD_IN,
  input  logic [DATA_W-1:0] RAM_IN,
  input  logic              IO64_ACK,
  output logic [DATA_W-1:0] RAM_0,
  output logic [DATA_W-1:0] RAM_1,
  output logic [DATA_W-1:0] RAM_2,
  output logic [DATA_W-1:0] RAM_3,
  output logic [DATA_W-1:0] RAM_4,
  output logic [DATA_W-1:0] RAM_5,
  output logic [DATA_W-1:0] RAM_6,
  output logic [DATA_W-1:0] RAM_7,
  output logic [DATA_W-1:0] IO64_OUT,
  output logic              IO64_VALID,
  output logic              RAM_BUSY,
  output logic              AD_ERR
);

  import cpu15_pkg::*;

  localparam int              IDX_W      = $clog2(RAM_DEPTH);
  localparam logic [AD_W-1:0] RAM_BASE_A = AD_W'(RAM_BASE);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic              ram_hit;
  logic              io_hit;
  logic              unmapped;
  logic [IDX_W-1:0]  ram_idx;

  // RAM window is an aligned block, so a match on the upper bits is enough;
  // the port claims a whole quarter of the map via the top two bits
  always_comb begin
    ram_hit  = (RAM_AD_IN[AD_W-1:IDX_W] == RAM_BASE_A[AD_W-1:IDX_W]);
    io_hit   = (RAM_AD_IN[AD_W-1 -: 2] == IO_MATCH);
    unmapped = !ram_hit && !io_hit;
    ram_idx  = RAM_AD_IN[IDX_W-1:0];
  end

  always_ff @(posedge CLK_WT) begin
    if (RESET) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= '0;
      AD_ERR <= 1'b0;
    end else begin
      if (RAM_WEN && ram_hit)  mem[ram_idx] <= RAM_IN;
      if (RAM_WEN && unmapped) AD_ERR       <= 1'b1;
    end
  end

  assign RAM_0 = mem[0];
  assign RAM_1 = mem[1];
  assign RAM_2 = mem[2];
  assign RAM_3 = mem[3];
  assign RAM_4 = mem[4];
  assign RAM_5 = mem[5];
  assign RAM_6 = mem[6];
  assign RAM_7 = mem[7];

  io_out_port #(
    .DATA_W (DATA_W)
  ) u_io_out_port (
    .clk   (CLK_WT),
    .rst   (RESET),
    .wr    (RAM_WEN && io_hit),
    .ack   (IO64_ACK),
    .din   (RAM_IN),
    .dout  (IO64_OUT),
    .valid (IO64_VALID),
    .busy  (RAM_BUSY)
  );

endmodule

// File: tb/tb_ram_wt.sv
module tb_ram_wt;

  localparam int K_RAM   = 0;
  localparam int K_IO    = 1;
  localparam int K_VALID = 2;
  localparam int K_BUSY  = 3;
  localparam int K_ERR   = 4;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  ad  = 8'h00;
  logic [15:0] din = 16'h0000;
  logic        ack = 1'b0;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] io_out;
  logic        io_valid, busy, ad_err;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  ram_wt dut (
    .CLK_WT     (clk),
    .RESET      (rst),
    .RAM_WEN    (wen),
    .RAM_AD_IN  (ad),
    .RAM_IN     (din),
    .IO64_ACK   (ack),
    .RAM_0      (r0),
    .RAM_1      (r1),
    .RAM_2      (r2),
    .RAM_3      (r3),
    .RAM_4      (r4),
    .RAM_5      (r5),
    .RAM_6      (r6),
    .RAM_7      (r7),
    .IO64_OUT   (io_out),
    .IO64_VALID (io_valid),
    .RAM_BUSY   (busy),
    .AD_ERR     (ad_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int kind, input int idx);
    logic [15:0] v;
    v = 16'hxxxx;
    case (kind)
      K_RAM: case (idx)
        0: v = r0; 1: v = r1; 2: v = r2; 3: v = r3;
        4: v = r4; 5: v = r5; 6: v = r6; default: v = r7;
      endcase
      K_IO:    v = io_out;
      K_VALID: v = {15'd0, io_valid};
      K_BUSY:  v = {15'd0, busy};
      default: v = {15'd0, ad_err};
    endcase
    return v;
  endfunction

  function automatic string kname(input int kind, input int idx);
    case (kind)
      K_RAM:   return $sformatf("RAM_%0d", idx);
      K_IO:    return "IO64_OUT";
      K_VALID: return "IO64_VALID";
      K_BUSY:  return "RAM_BUSY";
      default: return "AD_ERR";
    endcase
  endfunction

  // Monitor: compares every expectation due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] a;
      e = sb.pop_front();
      a = actual(e.kind, e.idx);
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", kname(e.kind, e.idx), e.cyc, cyc);
      end else if (a !== e.val) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", kname(e.kind, e.idx), cyc, a, e.val);
      end
    end
  end

  // dly=0: combinational value in the cycle being driven; dly=1: after the edge
  task automatic expect_v(input int kind, input int idx, input logic [15:0] val, input int dly);
    exp_t e;
    e.cyc = cyc + dly; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drive(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input logic k, input logic r);
    wen = w; ad = a; din = d; ack = k; rst = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ram_all(input logic [15:0] v [8], input int dly);
    for (int i = 0; i < 8; i++) expect_v(K_RAM, i, v[i], dly);
  endtask

  logic [15:0] vals  [8] = '{16'h6535, 16'h7628, 16'h7e6e, 16'habcd,
                             16'h64a6, 16'h0000, 16'h34b1, 16'h808d};
  logic [15:0] vals2 [8] = '{16'h6535, 16'h7628, 16'h0bad, 16'habcd,
                             16'h64a6, 16'h0000, 16'h34b1, 16'h808d};
  logic [15:0] zeros [8] = '{default: 16'h0000};

  initial begin
    #10000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    next_cycle();

    // reset: everything cleared, no stall during reset even with a held request
    drive(1'b1, 8'h40, 16'hdead, 1'b0, 1'b1);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_ram_all(zeros, 1);
    expect_v(K_IO, 0, 16'h0000, 1);
    expect_v(K_VALID, 0, 16'h0, 1);
    expect_v(K_ERR, 0, 16'h0, 1);
    next_cycle();

    // fill RAM words 0..7, each visible one cycle after its write
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), vals[i], 1'b0, 1'b0);
      expect_v(K_BUSY, 0, 16'h0, 0);
      expect_v(K_RAM, i, vals[i], 1);
      next_cycle();
    end
    // no write, garbage on the bus: nothing changes
    drive(1'b0, 8'h03, 16'hffff, 1'b1, 1'b0);
    expect_ram_all(vals, 0);
    expect_ram_all(vals, 1);
    expect_v(K_VALID, 0, 16'h0, 1);
    next_cycle();

    // port write in IDLE, then ack drains it
    drive(1'b1, 8'h40, 16'h324f, 1'b0, 1'b0);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_v(K_IO, 0, 16'h324f, 1);
    expect_v(K_VALID, 0, 16'h1, 1);
    next_cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0);
    expect_v(K_VALID, 0, 16'h0, 1);
    expect_v(K_IO, 0, 16'h324f, 1);
    next_cycle();
    // ack while IDLE is ignored
    drive(1'b0, 8'h40, 16'h5555, 1'b1, 1'b0);
    expect_v(K_VALID, 0, 16'h0, 1);
    expect_v(K_IO, 0, 16'h324f, 1);
    next_cycle();

    // refill via top of the port region, then stall, then ack releases the held write
    drive(1'b1, 8'h7f, 16'h324f, 1'b0, 1'b0);
    expect_v(K_VALID, 0, 16'h1, 1);
    next_cycle();
    drive(1'b1, 8'h40, 16'h1111, 1'b0, 1'b0);
    expect_v(K_BUSY, 0, 16'h1, 0);
    expect_v(K_IO, 0, 16'h324f, 1);
    expect_v(K_VALID, 0, 16'h1, 1);
    next_cycle();
    drive(1'b1, 8'h40, 16'h1111, 1'b1, 1'b0);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_v(K_IO, 0, 16'h1111, 1);
    expect_v(K_VALID, 0, 16'h1, 1);
    next_cycle();
    // RAM write while the port is FULL is never stalled
    drive(1'b1, 8'h02, 16'h0bad, 1'b0, 1'b0);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_v(K_RAM, 2, 16'h0bad, 1);
    expect_v(K_IO, 0, 16'h1111, 1);
    next_cycle();

    // unmapped writes: just above RAM, then the 10 region, then the 11 region
    drive(1'b1, 8'h08, 16'hffff, 1'b0, 1'b0);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_v(K_ERR, 0, 16'h1, 1);
    expect_ram_all(vals2, 1);
    next_cycle();
    drive(1'b1, 8'h80, 16'hffff, 1'b0, 1'b0);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_v(K_ERR, 0, 16'h1, 1);
    expect_v(K_IO, 0, 16'h1111, 1);
    expect_v(K_VALID, 0, 16'h1, 1);
    next_cycle();
    drive(1'b1, 8'hc0, 16'hffff, 1'b0, 1'b0);
    expect_ram_all(vals2, 1);
    next_cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    expect_v(K_ERR, 0, 16'h1, 1);
    next_cycle();

    // reset in FULL with a stalled port write: no busy, pending word dropped
    drive(1'b1, 8'h40, 16'h9999, 1'b0, 1'b1);
    expect_v(K_BUSY, 0, 16'h0, 0);
    expect_v(K_IO, 0, 16'h0000, 1);
    expect_v(K_VALID, 0, 16'h0, 1);
    expect_v(K_ERR, 0, 16'h0, 1);
    expect_ram_all(zeros, 1);
    next_cycle();

    // refill port and RAM_3, then reset alongside a RAM write to 8'h03
    drive(1'b1, 8'h40, 16'habcd, 1'b0, 1'b0);
    expect_v(K_VALID, 0, 16'h1, 1);
    next_cycle();
    drive(1'b1, 8'h03, 16'h7777, 1'b0, 1'b0);
    expect_v(K_RAM, 3, 16'h7777, 1);
    next_cycle();
    drive(1'b1, 8'h03, 16'h5a5a, 1'b1, 1'b1);
    expect_ram_all(zeros, 1);
    expect_v(K_IO, 0, 16'h0000, 1);
    expect_v(K_VALID, 0, 16'h0, 1);
    expect_v(K_BUSY, 0, 16'h0, 1);
    next_cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);

    repeat (2) next_cycle();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
